// File: rtl/decode_skid_stage.sv
// Decode stage with a two-entry (main + skid) output buffer of decoded instructions.
// Optional DECODE_TRAP_EN: invalid instructions raise except_valid instead of becoming a NOP.
module decode_skid_stage #(
    parameter int              ILEN      = 32,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] PC_EXCEPT = XLEN'(32'h00002000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_itype,
    output logic [4:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm
`ifdef DECODE_TRAP_EN
    ,
    output logic            except_valid,
    output logic [XLEN-1:0] except_pc
`endif
);

    localparam logic [2:0] IT_I = 3'd0, IT_R = 3'd1, IT_S = 3'd2, IT_B = 3'd3, IT_INV = 3'd4;
    localparam logic [4:0] OP_LW = 5'd0, OP_LB = 5'd1, OP_ADDI = 5'd2, OP_SUB = 5'd3, OP_ADD = 5'd4,
                           OP_MUL = 5'd5, OP_SW = 5'd6, OP_SB = 5'd7, OP_BEQ = 5'd8, OP_JUMP = 5'd9;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [2:0]      itype;
        logic [4:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
`ifdef DECODE_TRAP_EN
        logic            trap;
`endif
    } entry_t;

    entry_t      dec, head, skid;
    logic [31:0] ir, imm32;
    logic        dec_ok;
    logic [1:0]  count, count_next;
    logic        push, pop;

    assign ir = in_instr[31:0];

    always_comb begin
        dec       = '0;
        dec.instr = in_instr;
        dec.pc    = in_pc;
        dec.rd    = ir[11:7];
        dec.rs1   = ir[19:15];
        dec.rs2   = ir[24:20];
        dec_ok    = 1'b1;
        imm32     = '0;
        case (ir[6:0])
            7'b0000011: begin
                dec.itype = IT_I;
                imm32     = {{20{ir[31]}}, ir[31:20]};
                if (ir[14:12] == 3'b010)      dec.op = OP_LW;
                else if (ir[14:12] == 3'b000) dec.op = OP_LB;
                else                          dec_ok = 1'b0;
            end
            7'b0010011: begin
                dec.itype = IT_I;
                dec.op    = OP_ADDI;
                imm32     = {{20{ir[31]}}, ir[31:20]};
                dec_ok    = (ir[14:12] == 3'b000);
            end
            7'b0110011: begin
                dec.itype = IT_R;
                if (ir[14:12] != 3'b000)          dec_ok = 1'b0;
                else if (ir[31:25] == 7'b0000000) dec.op = OP_ADD;
                else if (ir[31:25] == 7'b0100000) dec.op = OP_SUB;
                else if (ir[31:25] == 7'b0000001) dec.op = OP_MUL;
                else                              dec_ok = 1'b0;
            end
            7'b0100011: begin
                dec.itype = IT_S;
                imm32     = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                if (ir[14:12] == 3'b010)      dec.op = OP_SW;
                else if (ir[14:12] == 3'b000) dec.op = OP_SB;
                else                          dec_ok = 1'b0;
            end
            7'b1100011: begin
                dec.itype = IT_B;
                dec.op    = OP_BEQ;
                imm32     = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
                dec_ok    = (ir[14:12] == 3'b000);
            end
            7'b1101111: begin
                dec.itype = IT_B;
                dec.op    = OP_JUMP;
                imm32     = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            default: dec_ok = 1'b0;
        endcase
        if (!dec_ok) begin
            imm32     = '0;
`ifdef DECODE_TRAP_EN
            dec.itype = IT_INV;
            dec.op    = OP_LW;
            dec.trap  = 1'b1;
`else
            // Unknown encodings are squashed to "addi x0, x0, 0".
            dec.instr = ILEN'(32'h00000013);
            dec.itype = IT_I;
            dec.op    = OP_ADDI;
            dec.rd    = '0;
            dec.rs1   = '0;
            dec.rs2   = '0;
`endif
        end
        dec.imm = XLEN'($signed(imm32));
    end

    // Handshake: a beat moves on a rising edge where valid && ready; in_ready is a
    // registered "fewer than two held" flag, so it never depends on out_ready.
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count;
        if (flush)             count_next = 2'd0;
        else if (push && !pop) count_next = count + 2'd1;
        else if (pop && !push) count_next = count - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            in_ready <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next != 2'd2);
            if (pop && count == 2'd2)             head <= skid;
            else if (push && (count == 2'd0 || pop)) head <= dec;
            if (push && !pop && count == 2'd1)    skid <= dec;
        end
    end

    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_itype = head.itype;
    assign out_op    = head.op;
    assign out_rd    = head.rd;
    assign out_rs1   = head.rs1;
    assign out_rs2   = head.rs2;
    assign out_imm   = head.imm;

`ifdef DECODE_TRAP_EN
    assign except_valid = out_valid && head.trap && !flush;
    assign except_pc    = PC_EXCEPT;
`endif

endmodule
